rgb_yuv_cvt: RTL and testbench
==============================

RGB_YUV_CVT -- requirements
Module: rgb_yuv_cvt

Interface
REQ-001 SHALL have parameter DW, default 8, component width in bits (legal 6..12).
REQ-002 SHALL have parameter CNTW, default 32, width of the output beat counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts the input beat.
REQ-007 SHALL have port in_mode  input  1  matrix select per beat (0 = BT.601, 1 = BT.709).
REQ-008 SHALL have ports in_r, in_g, in_b  input  DW each  unsigned RGB pixel.
REQ-009 SHALL have port out_valid  output  1  output beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output beat.
REQ-011 SHALL have ports out_y, out_u, out_v  output  DW each  unsigned YUV pixel.
REQ-012 SHALL have port pix_cnt  output  CNTW  count of completed output handshakes.

Function
REQ-013 SHALL transfer an input beat when in_valid && in_ready at a rising edge, and an output beat when out_valid && out_ready.
REQ-014 SHALL use signed Q8 coefficients. BT.601: Y 77/150/29, U -43/-85/128, V 128/-107/-21. BT.709: Y 54/183/19, U -29/-99/128, V 128/-116/-12 (R/G/B order).
REQ-015 SHALL compute each component as floor((sum + 128) / 256), with the arithmetic shift on full-precision signed sums; add offset 2^(DW-1) to U and V only.
REQ-016 SHALL latch in_mode with its beat, so a mode change between consecutive beats affects only later beats.
REQ-017 SHALL be a 3-stage pipeline (products, sums, round/offset/limit); a beat accepted at edge k presents out_valid at edge k+3 when out_ready is held high.
REQ-018 SHALL sustain one beat per cycle with out_ready high.
REQ-019 SHALL stall a stage only when it holds valid data and the next stage is stalled; bubbles SHALL collapse.
REQ-020 SHALL drive in_ready high iff stage 1 is empty or will advance this cycle; a combinational out_ready-to-in_ready path is permitted.
REQ-021 SHALL hold out_y/u/v/out_valid stable while out_valid && !out_ready.
REQ-022 SHALL never drop, duplicate or reorder beats under any in_valid/out_ready pattern.
REQ-023 SHALL increment pix_cnt by 1 per output handshake and wrap from 2^CNTW-1 to 0.

Reset
REQ-024 SHALL, on rst low, immediately clear all stage-valid flags, force out_valid=0, out_y/u/v=0, and pix_cnt=0, regardless of clk.
REQ-025 SHALL discard in-flight beats on mid-operation reset; in_ready SHALL be 0 while rst is low and SHALL go to 1 on the first edge after release.

Configuration
REQ-026 SHALL, with RGB_YUV_CLAMP_EN defined, saturate each output to [0, 2^DW-1].
REQ-027 SHALL, without RGB_YUV_CLAMP_EN, truncate each output to its low DW bits (modulo wrap).

Verification
REQ-028 Black (0,0,0), mode 0, DW=8 -> Y=0, U=128, V=128, out_valid 3 edges after acceptance.
REQ-029 White (255,255,255), mode 0 and mode 1 -> Y=255, U=128, V=128 for both.
REQ-030 Blue (0,0,255), mode 0 -> Y=29, V=107; U=255 with RGB_YUV_CLAMP_EN, U=0 without.
REQ-031 20 back-to-back beats with out_ready toggled pseudo-randomly, modes alternating -> outputs in order, each matches the reference model, pix_cnt=20, no gaps while out_ready is high.
REQ-032 rst pulled low with 3 beats in flight -> out_valid=0 and pix_cnt=0 immediately, and no stale beat appears after release.
REQ-033 CNTW=4 with 17 beats -> pix_cnt wraps at 15->0 and ends at 1.

Source files
------------

// File: rtl/rgb_yuv_cvt.sv
// rgb_yuv_cvt -- three-stage RGB to YUV converter with per-beat matrix select
// (0 = BT.601, 1 = BT.709), valid/ready flow control and an output beat counter.
// Stage 1 holds the nine coefficient products, stage 2 the three row sums,
// stage 3 the rounded, offset and limited outputs.
// Build option: define RGB_YUV_CLAMP_EN to saturate outputs to [0, 2^DW-1];
// without it each output keeps its low DW bits (modulo wrap).
module rgb_yuv_cvt #(
  parameter int DW   = 8,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [DW-1:0]   in_r,
  input  logic [DW-1:0]   in_g,
  input  logic [DW-1:0]   in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_y,
  output logic [DW-1:0]   out_u,
  output logic [DW-1:0]   out_v,
  output logic [CNTW-1:0] pix_cnt
);
  // Unsigned DW-bit pixel times signed 9-bit coefficient, with sign/headroom.
  localparam int PW  = DW + 11;
  localparam int SW  = DW + 13;
  localparam int OFS = 1 << (DW - 1);
`ifdef RGB_YUV_CLAMP_EN
  localparam int MAXV = (1 << DW) - 1;
`endif
  // Row-major: Y, U, V rows; R, G, B columns.
  localparam int C601 [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
  localparam int C709 [9] = '{54, 183, 19, -29, -99, 128, 128, -116, -12};

  logic                 rdy_q, rdy_d;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                 adv1, adv2, adv3, acc;
  logic signed [PW-1:0] px;
  logic signed [PW-1:0] prod_q [9];
  logic signed [PW-1:0] prod_d [9];
  logic signed [SW-1:0] sum_q [3];
  logic signed [SW-1:0] sum_d [3];
  logic signed [SW-1:0] rnd [3];
  logic [DW-1:0]        oy_q, ou_q, ov_q, oy_d, ou_d, ov_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;

  function automatic logic [DW-1:0] limit(input logic signed [SW-1:0] x);
`ifdef RGB_YUV_CLAMP_EN
    if (x < 0)              limit = '0;
    else if (x > SW'(MAXV)) limit = '1;
    else                    limit = DW'(x);
`else
    limit = DW'(x);
`endif
  endfunction

  // Stage advance chain; a stage moves when empty or when its successor moves.
  always_comb begin
    adv3     = !v3_q || out_ready;
    adv2     = !v2_q || adv3;
    adv1     = !v1_q || adv2;
    in_ready = rdy_q && adv1;
    acc      = in_valid && in_ready;
    rdy_d    = 1'b1;
    v1_d     = adv1 ? acc  : v1_q;
    v2_d     = adv2 ? v1_q : v2_q;
    v3_d     = adv3 ? v2_q : v3_q;
    cnt_d    = (v3_q && out_ready) ? cnt_q + CNTW'(1) : cnt_q;
  end

  // Stage 1: products, with the matrix chosen by the mode of this beat.
  always_comb begin
    px = '0;
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = prod_q[i];
      case (i % 3)
        0:       px = $signed(PW'(in_r));
        1:       px = $signed(PW'(in_g));
        default: px = $signed(PW'(in_b));
      endcase
      if (acc)
        prod_d[i] = px * (in_mode ? PW'(C709[i]) : PW'(C601[i]));
    end
  end

  // Stage 2: full-precision signed row sums.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      sum_d[r] = sum_q[r];
      if (adv2 && v1_q)
        sum_d[r] = SW'(prod_q[3*r]) + SW'(prod_q[3*r+1]) + SW'(prod_q[3*r+2]);
    end
  end

  // Stage 3: round half up via arithmetic shift, chroma offset, then limit.
  always_comb begin
    rnd[0] = (sum_q[0] + SW'(128)) >>> 8;
    rnd[1] = ((sum_q[1] + SW'(128)) >>> 8) + SW'(OFS);
    rnd[2] = ((sum_q[2] + SW'(128)) >>> 8) + SW'(OFS);
    oy_d   = oy_q;
    ou_d   = ou_q;
    ov_d   = ov_q;
    if (adv3 && v2_q) begin
      oy_d = limit(rnd[0]);
      ou_d = limit(rnd[1]);
      ov_d = limit(rnd[2]);
    end
  end

  // State registers; reset empties the pipe and holds off input until a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int r = 0; r < 3; r++) sum_q[r] <= '0;
      oy_q  <= '0;
      ou_q  <= '0;
      ov_q  <= '0;
      cnt_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int r = 0; r < 3; r++) sum_q[r] <= sum_d[r];
      oy_q  <= oy_d;
      ou_q  <= ou_d;
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = v3_q;
  assign out_y     = oy_q;
  assign out_u     = ou_q;
  assign out_v     = ov_q;
  assign pix_cnt   = cnt_q;

endmodule

// File: tb/tb_rgb_yuv_cvt.sv
// Bench for rgb_yuv_cvt: directed colour/latency/reset steps plus random
// traffic scored against an integer-arithmetic reference; a second instance
// with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_rgb_yuv_cvt;
  logic        clk, rst, in_valid, in_mode, out_ready;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_ready, out_valid;
  logic [7:0]  out_y, out_u, out_v;
  logic [31:0] pix_cnt;
  logic        w_in_ready, w_out_valid;
  logic [7:0]  w_y, w_u, w_v;
  logic [3:0]  w_pix_cnt;

  int total = 0;
  int bad = 0;
  int cnt_m = 0;
  logic [23:0] q[$];
  logic last_ih, last_oh;

`ifdef RGB_YUV_CLAMP_EN
  localparam int U_BLUE = 255;
`else
  localparam int U_BLUE = 0;
`endif

  rgb_yuv_cvt #(.DW(8), .CNTW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_u(out_u), .out_v(out_v), .pix_cnt(pix_cnt));

  rgb_yuv_cvt #(.DW(8), .CNTW(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_mode(in_mode), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_y(w_y), .out_u(w_u), .out_v(w_v), .pix_cnt(w_pix_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fdiv256(input int t);
    int d;
    d = t / 256;
    if (t < 0 && (t % 256) != 0) d = d - 1;
    return d;
  endfunction

  function automatic int lim(input int x);
`ifdef RGB_YUV_CLAMP_EN
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
`else
    return x & 255;
`endif
  endfunction

  function automatic logic [23:0] ref_yuv(input int r, input int g, input int b, input logic m);
    int k[9];
    int y, u, v;
    if (m) k = '{54, 183, 19, -29, -99, 128, 128, -116, -12};
    else   k = '{77, 150, 29, -43, -85, 128, 128, -107, -21};
    y = lim(fdiv256(k[0]*r + k[1]*g + k[2]*b + 128));
    u = lim(fdiv256(k[3]*r + k[4]*g + k[5]*b + 128) + 128);
    v = lim(fdiv256(k[6]*r + k[7]*g + k[8]*b + 128) + 128);
    return {8'(y), 8'(u), 8'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: called at posedge+1 with inputs already driven.
  task automatic tick();
    logic ih, oh, st;
    logic [23:0] held, wheld, e;
    #2;
    ih    = in_valid && in_ready;
    oh    = out_valid && out_ready;
    st    = out_valid && !out_ready;
    held  = {out_y, out_u, out_v};
    wheld = {w_y, w_u, w_v};
    if (ih) q.push_back(ref_yuv(int'(in_r), int'(in_g), int'(in_b), in_mode));
    @(posedge clk);
    #1;
    if (oh) begin
      if (q.size() == 0) begin
        chk("sb_extra_beat", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("sb_yuv", 32'(held), 32'(e));
        chk("sb_yuv_w", 32'(wheld), 32'(e));
      end
      cnt_m++;
    end
    if (st) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'({out_y, out_u, out_v}), 32'(held));
    end
    chk("pix_cnt", pix_cnt, 32'(cnt_m));
    chk("pix_cnt_w", 32'(w_pix_cnt), 32'(cnt_m % 16));
    last_ih = ih;
    last_oh = oh;
  endtask

  // Single isolated beat with latency check; called at posedge+1.
  task automatic one_beat(input string tag, input int r, input int g, input int b,
                          input logic m, input int ey, input int eu, input int ev);
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b); in_mode = m;
    in_valid = 1'b1; out_ready = 1'b1;
    #2;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat3"}, 32'(out_valid), 32'd1);
    chk({tag, "_y"}, 32'(out_y), 32'(ey));
    chk({tag, "_u"}, 32'(out_u), 32'(eu));
    chk({tag, "_v"}, 32'(out_v), 32'(ev));
    @(posedge clk); #1;
    cnt_m++;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    chk({tag, "_cnt"}, pix_cnt, 32'(cnt_m));
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    cnt_m = 0;
    q.delete();
  endtask

  task automatic new_pixel();
    in_r = 8'($urandom_range(0, 255));
    in_g = 8'($urandom_range(0, 255));
    in_b = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int sent, outs, gaps, cyc;
    logic started;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    last_ih = 1'b0; last_oh = 1'b0;

    // Power-on reset values and in_ready release timing.
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pix_cnt", pix_cnt, 32'd0);
    chk("rst_yuv", 32'({out_y, out_u, out_v}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("release_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("release_in_ready_high", 32'(in_ready), 32'd1);
    chk("release_in_ready_w", 32'(w_in_ready), 32'd1);

    // Directed colours.
    one_beat("black601", 0, 0, 0, 1'b0, 0, 128, 128);
    one_beat("white601", 255, 255, 255, 1'b0, 255, 128, 128);
    one_beat("white709", 255, 255, 255, 1'b1, 255, 128, 128);
    one_beat("blue601", 0, 0, 255, 1'b0, 29, U_BLUE, 107);

    // 20 back-to-back beats, random out_ready, alternating modes.
    reset_dut();
    sent = 0; cyc = 0;
    new_pixel();
    while ((sent < 20 || q.size() != 0) && cyc < 600) begin
      in_valid  = (sent < 20);
      in_mode   = 1'(sent % 2);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_ih) begin
        sent++;
        new_pixel();
      end
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd20);
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("rand_pix_cnt", pix_cnt, 32'd20);

    // Full throughput: no gaps once outputs start with out_ready high.
    sent = 0; outs = 0; gaps = 0; cyc = 0; started = 1'b0;
    out_ready = 1'b1;
    while ((sent < 10 || outs < 10) && cyc < 100) begin
      in_valid = (sent < 10);
      in_mode  = 1'($urandom_range(0, 1));
      tick();
      if (last_ih) begin
        sent++;
        new_pixel();
      end
      if (last_oh) begin
        started = 1'b1;
        outs++;
      end else if (started && outs < 10) begin
        gaps++;
      end
      cyc++;
    end
    chk("thru_outs", 32'(outs), 32'd10);
    chk("thru_gaps", 32'(gaps), 32'd0);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (last_ih) new_pixel();
    end
    in_valid = 1'b0;
    chk("inflight_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_pix_cnt", pix_cnt, 32'd0);
    chk("midrst_yuv", 32'({out_y, out_u, out_v}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    cnt_m = 0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_release_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_release_high", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale", 32'(out_valid), 32'd0);
    end

    // 17 beats: the 4-bit counter wraps 15 -> 0 and ends at 1.
    reset_dut();
    sent = 0; outs = 0; cyc = 0;
    out_ready = 1'b1;
    new_pixel();
    while ((sent < 17 || q.size() != 0) && cyc < 200) begin
      in_valid = (sent < 17);
      in_mode  = 1'($urandom_range(0, 1));
      tick();
      if (last_ih) begin
        sent++;
        new_pixel();
      end
      cyc++;
    end
    chk("wrap_sent", 32'(sent), 32'd17);
    chk("wrap_pix_cnt", pix_cnt, 32'd17);
    chk("wrap_pix_cnt_w", 32'(w_pix_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
